// File: rtl/seg7_if.sv
// seg7_if: BCD digit frame in, multiplexed active-low seven-segment drive out.
interface seg7_if;
  logic [15:0] digits;
  logic [3:0] dp_in;
  logic [3:0] blink_en;
  logic blank_lz;
  logic [6:0] seg_n;
  logic dp_n;
  logic [3:0] an_n;
  logic frame_start;
  modport master(output digits, dp_in, blink_en, blank_lz, input seg_n, dp_n, an_n, frame_start);
  modport slave(input digits, dp_in, blink_en, blank_lz, output seg_n, dp_n, an_n, frame_start);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment driver with blink and leading-zero blanking.
module seg7_scan_driver #(
  parameter int IN_CLK_HZ = 50_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_HZ = 2
) (
  input logic clk,
  input logic rst,
  seg7_if.slave bus
);
  localparam int SLOT = IN_CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = IN_CLK_HZ / (2 * BLINK_HZ);
  localparam int CW = SLOT > 1 ? $clog2(SLOT) : 1;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  generate
    if (GUARD_CYCLES >= SLOT) begin : g_bad_guard
      $error("GUARD_CYCLES must be smaller than the slot length");
    end
  endgenerate
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [BW-1:0] bcnt;
  logic bph;
  logic [15:0] frm;
  logic [3:0] frm_dp;
  logic [3:0] frm_blk;
  logic frm_lz;
  logic slot_end;
  logic blink_end;
  logic guard;
  logic [3:0] nib;
  logic [3:0] lz_blank;
  logic blank;
  logic [6:0] seg;
  assign slot_end = cnt == CW'(SLOT - 1);
  assign blink_end = bcnt == BW'(BLINK_HALF - 1);
  assign guard = cnt < CW'(GUARD_CYCLES);
  assign nib = frm[{idx, 2'b00} +: 4];
  // a digit is a leading zero only if it and every digit to its left are zero
  always_comb begin
    lz_blank = '0;
    lz_blank[3] = frm_lz && frm[15:12] == 4'd0;
    lz_blank[2] = lz_blank[3] && frm[11:8] == 4'd0;
    lz_blank[1] = lz_blank[2] && frm[7:4] == 4'd0;
  end
  assign blank = lz_blank[idx] | (frm_blk[idx] & bph);
  always_comb begin
    seg = 7'b0111111;
    case (nib)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      bcnt <= '0;
      bph <= 1'b0;
      frm <= '0;
      frm_dp <= '0;
      frm_blk <= '0;
      frm_lz <= 1'b0;
      bus.seg_n <= '1;
      bus.dp_n <= 1'b1;
      bus.an_n <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= slot_end ? idx + 1'b1 : idx;
      bcnt <= blink_end ? '0 : bcnt + 1'b1;
      bph <= blink_end ? ~bph : bph;
      // capture only at the end of the last slot so a frame never tears
      if (slot_end && idx == 2'd3) begin
        frm <= bus.digits;
        frm_dp <= bus.dp_in;
        frm_blk <= bus.blink_en;
        frm_lz <= bus.blank_lz;
      end
      bus.seg_n <= blank ? '1 : seg;
      bus.dp_n <= blank | ~frm_dp[idx];
      bus.an_n <= guard ? '1 : ~(4'b0001 << idx);
      bus.frame_start <= idx == 2'd0 && cnt == '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: vector table, hand sequences and random stimulus against a time-based model.
module tb_seg7_scan_driver;
  localparam int SLOT = 10;
  localparam int GUARD = 2;
  localparam int BHALF = 250;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg7_if bus();
  seg7_scan_driver #(.IN_CLK_HZ(1000), .SCAN_HZ(100), .GUARD_CYCLES(GUARD), .BLINK_HZ(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] d;
    logic [3:0] dp;
    logic lz;
    int slot;
    logic [6:0] seg;
    logic dpn;
  } vec_t;
  vec_t vecs[15];
  int tests = 0;
  int fails = 0;
  int t = 0;
  logic [15:0] m_d = '0;
  logic [3:0] m_dp = '0;
  logic [3:0] m_blk = '0;
  logic m_lz = 1'b0;
  logic [6:0] e_seg;
  logic e_dp;
  logic [3:0] e_an;
  logic e_fs;
  logic [6:0] seg_tab[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  function automatic logic [12:0] outs();
    return {bus.seg_n, bus.dp_n, bus.an_n, bus.frame_start};
  endfunction
  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got seg=%b dp=%b an=%b fs=%b, expected seg=%b dp=%b an=%b fs=%b",
               name, t, got[12:6], got[5], got[4:1], got[0], exp[12:6], exp[5], exp[4:1], exp[0]);
    end
  endtask
  // model: state is a pure function of cycles since reset; the frame is sampled every 4th slot end
  task automatic tick();
    int idx;
    logic blank;
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_d = '0;
      m_dp = '0;
      m_blk = '0;
      m_lz = 1'b0;
      {e_seg, e_dp, e_an, e_fs} = {7'h7f, 1'b1, 4'hf, 1'b0};
    end else begin
      idx = (t / SLOT) % 4;
      blank = (m_blk[idx] && ((t / BHALF) % 2 == 1)) || (m_lz && idx != 0 && (m_d >> (4 * idx)) == 16'd0);
      e_seg = blank ? 7'h7f : seg_tab[4'(m_d >> (4 * idx))];
      e_dp = blank | ~m_dp[idx];
      e_an = (t % SLOT) < GUARD ? 4'hf : ~(4'b0001 << idx);
      e_fs = t % (4 * SLOT) == 0;
      if (t % (4 * SLOT) == 4 * SLOT - 1) begin
        m_d = bus.digits;
        m_dp = bus.dp_in;
        m_blk = bus.blink_en;
        m_lz = bus.blank_lz;
      end
      t++;
    end
    #1;
    check("model", outs(), {e_seg, e_dp, e_an, e_fs});
  endtask
  task automatic run_to(input int tt);
    int k = 0;
    while (t != tt + 1 && k < 2000) begin
      tick();
      k++;
    end
    if (t != tt + 1) begin
      tests++;
      fails++;
      $display("FAIL run_to timeout: at t=%0d, wanted t=%0d", t, tt + 1);
    end
  endtask
  task automatic wait_slot(input int s);
    int k = 0;
    while (!(t % SLOT == 5 && (t / SLOT) % 4 == s) && k < 50) begin
      tick();
      k++;
    end
    tick();
  endtask
  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk, input logic lz);
    bus.digits = d;
    bus.dp_in = dp;
    bus.blink_en = blk;
    bus.blank_lz = lz;
  endtask
  initial begin
    int fs_cnt;
    vecs[0] = '{16'h1234, 4'b0100, 1'b0, 0, 7'b0011001, 1'b1};
    vecs[1] = '{16'h1234, 4'b0100, 1'b0, 1, 7'b0110000, 1'b1};
    vecs[2] = '{16'h1234, 4'b0100, 1'b0, 2, 7'b0100100, 1'b0};
    vecs[3] = '{16'h1234, 4'b0100, 1'b0, 3, 7'b1111001, 1'b1};
    vecs[4] = '{16'h0050, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1};
    vecs[5] = '{16'h0050, 4'b0000, 1'b1, 2, 7'b1111111, 1'b1};
    vecs[6] = '{16'h0050, 4'b0000, 1'b1, 1, 7'b0010010, 1'b1};
    vecs[7] = '{16'h0050, 4'b0000, 1'b1, 0, 7'b1000000, 1'b1};
    vecs[8] = '{16'h0000, 4'b0000, 1'b1, 1, 7'b1111111, 1'b1};
    vecs[9] = '{16'h0000, 4'b0000, 1'b1, 0, 7'b1000000, 1'b1};
    vecs[10] = '{16'h00A0, 4'b0000, 1'b0, 1, 7'b0111111, 1'b1};
    vecs[11] = '{16'h00A0, 4'b0000, 1'b0, 2, 7'b1000000, 1'b1};
    vecs[12] = '{16'h7896, 4'b1111, 1'b1, 3, 7'b1111000, 1'b0};
    vecs[13] = '{16'h0905, 4'b1000, 1'b1, 3, 7'b1111111, 1'b1};
    vecs[14] = '{16'h0905, 4'b1000, 1'b1, 2, 7'b0010000, 1'b1};
    set_in(16'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("post_reset", outs(), {7'h7f, 1'b1, 4'hf, 1'b0});
    tick();
    check("slot0_cyc1", outs(), {7'b1000000, 1'b1, 4'hf, 1'b1});
    tick();
    for (int c = 3; c <= 10; c++) begin
      tick();
      check("slot0_lit", outs(), {7'b1000000, 1'b1, 4'b1110, 1'b0});
    end
    foreach (vecs[i]) begin
      set_in(vecs[i].d, vecs[i].dp, 4'h0, vecs[i].lz);
      repeat (4 * SLOT + 1) tick();
      wait_slot(vecs[i].slot);
      check($sformatf("vec%0d", i), outs(), {vecs[i].seg, vecs[i].dpn, ~(4'b0001 << vecs[i].slot), 1'b0});
    end
    fs_cnt = 0;
    for (int k = 0; k < 8 * SLOT; k++) begin
      tick();
      fs_cnt += int'(bus.frame_start);
    end
    tests++;
    if (fs_cnt != 2) begin
      fails++;
      $display("FAIL frame_start_rate: got %0d pulses, expected 2", fs_cnt);
    end
    set_in(16'h1111, 4'h0, 4'h0, 1'b0);
    repeat (4 * SLOT + 5) tick();
    wait_slot(1);
    set_in(16'h9999, 4'h0, 4'h0, 1'b0);
    wait_slot(2);
    check("tear_slot2", outs(), {7'b1111001, 1'b1, 4'b1011, 1'b0});
    wait_slot(3);
    check("tear_slot3", outs(), {7'b1111001, 1'b1, 4'b0111, 1'b0});
    wait_slot(0);
    check("tear_new_frame", outs(), {7'b0010000, 1'b1, 4'b1110, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(16'h1234, 4'b0001, 4'b0011, 1'b0);
    run_to(45);
    check("blink_on_d0", outs(), {7'b0011001, 1'b0, 4'b1110, 1'b0});
    run_to(255);
    check("blink_off_d1", outs(), {7'b1111111, 1'b1, 4'b1101, 1'b0});
    run_to(265);
    check("blink_d2_unaffected", outs(), {7'b0100100, 1'b1, 4'b1011, 1'b0});
    run_to(285);
    check("blink_off_d0_dp", outs(), {7'b1111111, 1'b1, 4'b1110, 1'b0});
    run_to(525);
    check("blink_back_on", outs(), {7'b0011001, 1'b0, 4'b1110, 1'b0});
    run_to(545);
    rst = 1'b1;
    tick();
    check("reset_mid_slot", outs(), {7'h7f, 1'b1, 4'hf, 1'b0});
    rst = 1'b0;
    run_to(5);
    check("after_reset_zero", outs(), {7'b1000000, 1'b1, 4'b1110, 1'b0});
    run_to(15);
    check("after_reset_d1", outs(), {7'b1000000, 1'b1, 4'b1101, 1'b0});
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0)
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      rst = $urandom_range(499) == 0;
      tick();
    end
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
